acl_spi_slave: RTL and testbench

- ADXL362-compatible SPI responder: the device end of the accelerometer SPI link.
- Serves a small register map containing device IDs, X/Y/Z samples, status, FILTER_CTL and POWER_CTL.
- Used as a bench/loopback model for the accelerometer master, and as a stand-in sensor on a second board.
- Runs in the CLK100MHZ domain and oversamples SCLK, MOSI and CSN.

---
 rtl/acl_pkg.sv | 44 ++++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/acl_spi_slave.sv | 235 +++++++++++++++++++++++
 tb/tb_acl_spi_slave.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/acl_pkg.sv
// acl_pkg: shared definitions for the ADXL362-compatible SPI responder.
//   - SPI command opcodes
//   - register map addresses (6-bit address space, wraps 0x3F -> 0x00)
//   - FSM state encoding
//   - helper for the sign-extended high byte of a 12-bit sample
package acl_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;

    localparam logic [5:0] ADDR_DEVID_AD   = 6'h00;
    localparam logic [5:0] ADDR_DEVID_MST  = 6'h01;
    localparam logic [5:0] ADDR_PARTID     = 6'h02;
    localparam logic [5:0] ADDR_REVID      = 6'h03;
    localparam logic [5:0] ADDR_XDATA      = 6'h08;
    localparam logic [5:0] ADDR_YDATA      = 6'h09;
    localparam logic [5:0] ADDR_ZDATA      = 6'h0A;
    localparam logic [5:0] ADDR_STATUS     = 6'h0B;
    localparam logic [5:0] ADDR_XDATA_L    = 6'h0E;
    localparam logic [5:0] ADDR_XDATA_H    = 6'h0F;
    localparam logic [5:0] ADDR_YDATA_L    = 6'h10;
    localparam logic [5:0] ADDR_YDATA_H    = 6'h11;
    localparam logic [5:0] ADDR_ZDATA_L    = 6'h12;
    localparam logic [5:0] ADDR_ZDATA_H    = 6'h13;
    localparam logic [5:0] ADDR_FILTER_CTL = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL  = 6'h2D;

    localparam logic [7:0] FILTER_CTL_RST = 8'h13;
    localparam logic [7:0] POWER_CTL_RST  = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_IGNORE
    } state_t;

    // High byte of a 12-bit two's-complement sample, sign-extended to 8 bits.
    function automatic logic [7:0] hi_byte(input logic [11:0] s);
        return {{4{s[11]}}, s[11:8]};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: SYNC_STAGES-deep synchronizer plus rise/fall detection.
// Ports:
//   clk     - system clock
//   i_d     - asynchronous input
//   o_sync  - synchronized level
//   o_rise  - one-cycle pulse on synchronized 0->1
//   o_fall  - one-cycle pulse on synchronized 1->0
// The chain is deliberately not reset: the top relies on the synchronized
// csn level staying valid through a reset to decide where the FSM resumes.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic i_d,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        r_prev <= r_sync[SYNC_STAGES-1];
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule

// File: rtl/acl_spi_slave.sv
// acl_spi_slave: ADXL362-compatible SPI mode-0 responder, oversampled in the
// CLK100MHZ domain.
// Ports:
//   CLK100MHZ    - system clock
//   reset        - synchronous active-high reset
//   sclk/mosi/csn- SPI from master (asynchronous, synchronized here)
//   miso         - slave data, 0 whenever not shifting a read byte
//   x_in/y_in/z_in, sample_valid - new sample interface
//   power_ctl/filter_ctl - writable control registers 0x2D/0x2C
//   busy         - synchronized chip-select active
module acl_spi_slave
    import acl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  DEVID_AD    = 8'hAD,
    parameter logic [7:0]  DEVID_MST   = 8'h1D,
    parameter logic [7:0]  PARTID      = 8'hF2,
    parameter logic [7:0]  REVID       = 8'h01
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        csn,
    output logic        miso,
    input  logic [11:0] x_in,
    input  logic [11:0] y_in,
    input  logic [11:0] z_in,
    input  logic        sample_valid,
    output logic [7:0]  power_ctl,
    output logic [7:0]  filter_ctl,
    output logic        busy
);

    logic w_sclk_rise, w_sclk_fall, w_sclk_sync_unused;
    logic w_csn_sync, w_csn_rise, w_csn_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk    (CLK100MHZ),
        .i_d    (sclk),
        .o_sync (w_sclk_sync_unused),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_csn_sync (
        .clk    (CLK100MHZ),
        .i_d    (csn),
        .o_sync (w_csn_sync),
        .o_rise (w_csn_rise),
        .o_fall (w_csn_fall)
    );

    // Same depth as sclk so mosi is sampled at the matching instant.
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   w_mosi;

    always_ff @(posedge CLK100MHZ) begin
        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
    end
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    state_t      r_state;
    logic [2:0]  r_bitcnt;
    logic [7:0]  r_rx_shift;
    logic [7:0]  r_tx_shift;
    logic [5:0]  r_addr;
    logic        r_is_read;
    logic        r_miso;
    logic [7:0]  r_filter_ctl;
    logic [7:0]  r_power_ctl;
    logic        r_data_ready;
    logic [11:0] r_x_live, r_y_live, r_z_live;
    logic [11:0] r_x_snap, r_y_snap, r_z_snap;

    logic [7:0]  w_rx_byte;
    logic        w_byte_done;
    logic [5:0]  w_rd_addr;
    logic [7:0]  w_rd_data;
    logic        w_status_clr;

    assign w_rx_byte   = {r_rx_shift[6:0], w_mosi};
    assign w_byte_done = w_sclk_rise && (r_bitcnt == 3'd7);

    // Address whose contents are loaded into tx_shift at the current byte end:
    // the freshly received address, or the auto-incremented one in DATA.
    assign w_rd_addr = (r_state == ST_ADDR) ? w_rx_byte[5:0] : r_addr + 6'd1;

    always_comb begin
        w_rd_data = 8'h00;
        case (w_rd_addr)
            ADDR_DEVID_AD:   w_rd_data = DEVID_AD;
            ADDR_DEVID_MST:  w_rd_data = DEVID_MST;
            ADDR_PARTID:     w_rd_data = PARTID;
            ADDR_REVID:      w_rd_data = REVID;
            ADDR_XDATA:      w_rd_data = r_x_snap[11:4];
            ADDR_YDATA:      w_rd_data = r_y_snap[11:4];
            ADDR_ZDATA:      w_rd_data = r_z_snap[11:4];
            ADDR_STATUS:     w_rd_data = {7'b0, r_data_ready};
            ADDR_XDATA_L:    w_rd_data = r_x_snap[7:0];
            ADDR_XDATA_H:    w_rd_data = hi_byte(r_x_snap);
            ADDR_YDATA_L:    w_rd_data = r_y_snap[7:0];
            ADDR_YDATA_H:    w_rd_data = hi_byte(r_y_snap);
            ADDR_ZDATA_L:    w_rd_data = r_z_snap[7:0];
            ADDR_ZDATA_H:    w_rd_data = hi_byte(r_z_snap);
            ADDR_FILTER_CTL: w_rd_data = r_filter_ctl;
            ADDR_POWER_CTL:  w_rd_data = r_power_ctl;
            default:         w_rd_data = 8'h00;
        endcase
    end

    assign w_status_clr = w_byte_done && r_is_read && !w_csn_rise &&
                          ((r_state == ST_ADDR) || (r_state == ST_DATA)) &&
                          (w_rd_addr == ADDR_STATUS);

    // Sample capture: live regs track sample_valid, snapshot is frozen at
    // csn_fall (taking a coincident new sample).
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_x_live     <= '0;
            r_y_live     <= '0;
            r_z_live     <= '0;
            r_x_snap     <= '0;
            r_y_snap     <= '0;
            r_z_snap     <= '0;
            r_data_ready <= 1'b0;
        end else begin
            if (sample_valid) begin
                r_x_live <= x_in;
                r_y_live <= y_in;
                r_z_live <= z_in;
            end
            if (w_csn_fall) begin
                r_x_snap <= sample_valid ? x_in : r_x_live;
                r_y_snap <= sample_valid ? y_in : r_y_live;
                r_z_snap <= sample_valid ? z_in : r_z_live;
            end
            if (sample_valid)
                r_data_ready <= 1'b1;
            else if (w_status_clr)
                r_data_ready <= 1'b0;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            // Resume in IGNORE if a transfer is in flight so its remaining
            // bits are not misread as a new command.
            r_state      <= w_csn_sync ? ST_IDLE : ST_IGNORE;
            r_bitcnt     <= '0;
            r_rx_shift   <= '0;
            r_tx_shift   <= '0;
            r_addr       <= '0;
            r_is_read    <= 1'b0;
            r_miso       <= 1'b0;
            r_filter_ctl <= FILTER_CTL_RST;
            r_power_ctl  <= POWER_CTL_RST;
        end else if (w_csn_rise) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= '0;
            r_miso   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_miso <= 1'b0;
                    if (w_csn_fall) begin
                        r_state  <= ST_CMD;
                        r_bitcnt <= '0;
                    end
                end
                ST_CMD: begin
                    if (w_sclk_rise) begin
                        r_rx_shift <= w_rx_byte;
                        r_bitcnt   <= r_bitcnt + 3'd1;
                        if (w_byte_done) begin
                            if (w_rx_byte == CMD_READ) begin
                                r_state   <= ST_ADDR;
                                r_is_read <= 1'b1;
                            end else if (w_rx_byte == CMD_WRITE) begin
                                r_state   <= ST_ADDR;
                                r_is_read <= 1'b0;
                            end else begin
                                r_state <= ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_sclk_rise) begin
                        r_rx_shift <= w_rx_byte;
                        r_bitcnt   <= r_bitcnt + 3'd1;
                        if (w_byte_done) begin
                            r_addr     <= w_rx_byte[5:0];
                            r_tx_shift <= w_rd_data;
                            r_state    <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (r_is_read && w_sclk_fall) begin
                        r_miso     <= r_tx_shift[7];
                        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                    end
                    if (w_sclk_rise) begin
                        r_rx_shift <= w_rx_byte;
                        r_bitcnt   <= r_bitcnt + 3'd1;
                        if (w_byte_done) begin
                            r_addr <= r_addr + 6'd1;
                            if (r_is_read) begin
                                r_tx_shift <= w_rd_data;
                            end else if (r_addr == ADDR_FILTER_CTL) begin
                                r_filter_ctl <= w_rx_byte;
                            end else if (r_addr == ADDR_POWER_CTL) begin
                                r_power_ctl <= w_rx_byte;
                            end
                        end
                    end
                end
                ST_IGNORE: begin
                    r_miso <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_miso  <= 1'b0;
                end
            endcase
        end
    end

    assign miso       = r_miso;
    assign power_ctl  = r_power_ctl;
    assign filter_ctl = r_filter_ctl;
    assign busy       = ~w_csn_sync;

endmodule

// File: tb/tb_acl_spi_slave.sv
// tb_acl_spi_slave: directed self-checking bench for acl_spi_slave.
// Acts as an SPI mode-0 master at 5 MHz (100 ns half period).
module tb_acl_spi_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk;
    logic        mosi;
    logic        csn;
    logic        miso;
    logic [11:0] x_in, y_in, z_in;
    logic        sample_valid;
    logic [7:0]  power_ctl;
    logic [7:0]  filter_ctl;
    logic        busy;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [7:0]  rx;

    always #5 clk = ~clk;

    acl_spi_slave #(
        .SYNC_STAGES (2),
        .DEVID_AD    (8'hAD),
        .DEVID_MST   (8'h1D),
        .PARTID      (8'hF2),
        .REVID       (8'h01)
    ) dut (
        .CLK100MHZ    (clk),
        .reset        (reset),
        .sclk         (sclk),
        .mosi         (mosi),
        .csn          (csn),
        .miso         (miso),
        .x_in         (x_in),
        .y_in         (y_in),
        .z_in         (z_in),
        .sample_valid (sample_valid),
        .power_ctl    (power_ctl),
        .filter_ctl   (filter_ctl),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Shift n bits MSB-first; miso is sampled just before each rising edge.
    task automatic spi_bits(input logic [7:0] tx, input int unsigned n, output logic [7:0] r);
        r = '0;
        for (int unsigned i = 0; i < n; i++) begin
            mosi = tx[7-i];
            #100;
            r = {r[6:0], miso};
            sclk = 1'b1;
            #100;
            sclk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] r);
        spi_bits(tx, 8, r);
    endtask

    task automatic cs_low();
        csn = 1'b0;
        #100;
    endtask

    task automatic cs_high();
        #100;
        csn = 1'b1;
        #200;
    endtask

    task automatic pulse_sample(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
        @(negedge clk);
        x_in = x; y_in = y; z_in = z;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sclk = 1'b0; mosi = 1'b0; csn = 1'b1;
        x_in = '0; y_in = '0; z_in = '0; sample_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_miso", {7'b0, miso}, 8'h00);
        chk("rst_power", power_ctl, 8'h00);
        chk("rst_filter", filter_ctl, 8'h13);
        chk("rst_busy", {7'b0, busy}, 8'h00);

        // ID read
        cs_low();
        chk("id_busy_lo", {7'b0, busy}, 8'h01);
        xfer(8'h0B, rx); xfer(8'h00, rx);
        xfer(8'h00, rx); chk("id_ad", rx, 8'hAD);
        xfer(8'h00, rx); chk("id_1d", rx, 8'h1D);
        xfer(8'h00, rx); chk("id_f2", rx, 8'hF2);
        xfer(8'h00, rx); chk("id_01", rx, 8'h01);
        chk("id_busy_end", {7'b0, busy}, 8'h01);
        cs_high();
        chk("id_busy_hi", {7'b0, busy}, 8'h00);
        chk("id_miso_hi", {7'b0, miso}, 8'h00);

        // Burst read of sample registers
        pulse_sample(12'h8A5, 12'h07F, 12'hFFF);
        cs_low();
        xfer(8'h0B, rx); xfer(8'h0E, rx);
        xfer(8'h00, rx); chk("burst_xl", rx, 8'hA5);
        xfer(8'h00, rx); chk("burst_xh", rx, 8'hF8);
        xfer(8'h00, rx); chk("burst_yl", rx, 8'h7F);
        xfer(8'h00, rx); chk("burst_yh", rx, 8'h00);
        xfer(8'h00, rx); chk("burst_zl", rx, 8'hFF);
        xfer(8'h00, rx); chk("burst_zh", rx, 8'hFF);
        cs_high();

        // Snapshot coherence
        cs_low();
        xfer(8'h0B, rx); xfer(8'h0E, rx);
        xfer(8'h00, rx); chk("snap_xl", rx, 8'hA5);
        pulse_sample(12'h123, 12'h07F, 12'hFFF);
        xfer(8'h00, rx); chk("snap_xh_old", rx, 8'hF8);
        cs_high();
        cs_low();
        xfer(8'h0B, rx); xfer(8'h0E, rx);
        xfer(8'h00, rx); chk("snap_xl_new", rx, 8'h23);
        xfer(8'h00, rx); chk("snap_xh_new", rx, 8'h01);
        cs_high();

        // Writes
        cs_low();
        xfer(8'h0A, rx); xfer(8'h2D, rx); xfer(8'h02, rx);
        cs_high();
        chk("wr_power", power_ctl, 8'h02);
        chk("wr_filter_keep", filter_ctl, 8'h13);
        cs_low();
        xfer(8'h0A, rx); xfer(8'h00, rx); xfer(8'h55, rx);
        cs_high();
        cs_low();
        xfer(8'h0B, rx); xfer(8'h2D, rx);
        xfer(8'h00, rx); chk("rd_power", rx, 8'h02);
        cs_high();
        cs_low();
        xfer(8'h0B, rx); xfer(8'h00, rx);
        xfer(8'h00, rx); chk("wr_ro_id", rx, 8'hAD);
        cs_high();

        // Aborted write: partial data byte must not be written
        cs_low();
        xfer(8'h0A, rx); xfer(8'h2C, rx);
        spi_bits(8'hF0, 4, rx);
        cs_high();
        chk("abort_filter", filter_ctl, 8'h13);

        // Unknown command
        cs_low();
        xfer(8'h77, rx);
        xfer(8'h00, rx); chk("unk_b0", rx, 8'h00);
        xfer(8'h00, rx); chk("unk_b1", rx, 8'h00);
        cs_high();

        // STATUS set and clear-on-read
        pulse_sample(12'h123, 12'h07F, 12'hFFF);
        cs_low();
        xfer(8'h0B, rx); xfer(8'h0B, rx);
        xfer(8'h00, rx); chk("status_set", rx, 8'h01);
        cs_high();
        cs_low();
        xfer(8'h0B, rx); xfer(8'h0B, rx);
        xfer(8'h00, rx); chk("status_clr", rx, 8'h00);
        cs_high();

        // Address wrap
        cs_low();
        xfer(8'h0B, rx); xfer(8'h3F, rx);
        xfer(8'h00, rx); chk("wrap_3f", rx, 8'h00);
        xfer(8'h00, rx); chk("wrap_00", rx, 8'hAD);
        cs_high();

        // Reset mid-read
        cs_low();
        xfer(8'h0B, rx); xfer(8'h00, rx);
        xfer(8'h00, rx); chk("rstmid_ad", rx, 8'hAD);
        spi_bits(8'h00, 4, rx);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_miso", {7'b0, miso}, 8'h00);
        chk("rstmid_power", power_ctl, 8'h00);
        chk("rstmid_busy", {7'b0, busy}, 8'h01);
        spi_bits(8'hFF, 4, rx); chk("rstmid_ign_nib", rx, 8'h00);
        xfer(8'h0B, rx); chk("rstmid_ign_b0", rx, 8'h00);
        xfer(8'h00, rx); chk("rstmid_ign_b1", rx, 8'h00);
        chk("rstmid_power2", power_ctl, 8'h00);
        cs_high();
        cs_low();
        xfer(8'h0B, rx); xfer(8'h00, rx);
        xfer(8'h00, rx); chk("rstmid_next_ad", rx, 8'hAD);
        cs_high();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
